// File: rtl/rightmove_seq.sv
// rightmove_seq: sequential right shifter, one bit position per clock.
//   Shifts a WIDTH-bit operand right by a runtime amount and produces a
//   sticky bit (OR of every bit shifted out) for alignment/rounding.
//   Valid/ready handshake on both input and output.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   I, amt, arith         operand, shift amount (0..WIDTH-1), sign-fill request
//   in_valid / in_ready   input handshake (in_ready high only in IDLE)
//   F, sticky             registered result, valid while out_valid
//   out_valid / out_ready output handshake (out_valid high only in DONE)
//
// Build option:
//   RSHIFT_ARITH_EN  defined: arith=1 fills with I[WIDTH-1] latched at accept.
//                    undefined: arith ignored, zero fill, no fill register.
module rightmove_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I,
  input  logic [SHW-1:0]   amt,
  input  logic             arith,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] F,
  output logic             sticky,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [SHW-1:0]   cnt;
  logic             sticky_q;
  logic             fill;

`ifdef RSHIFT_ARITH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fill <= 1'b0;
    else if (state == IDLE && in_valid)
      fill <= arith & I[WIDTH-1];
  end
`else
  // Logical shift only; arith is kept on the port for drop-in compatibility.
  logic unused_arith;
  assign unused_arith = arith;
  assign fill         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data     <= '0;
      cnt      <= '0;
      sticky_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= I;
            cnt      <= amt;
            sticky_q <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // cnt==0 check first so the counter can never wrap.
          if (cnt != '0) begin
            data     <= {fill, data[WIDTH-1:1]};
            sticky_q <= sticky_q | data[0];
            cnt      <= cnt - SHW'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign F         = data;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_rightmove_seq.sv
// tb_rightmove_seq: directed self-checking bench for rightmove_seq.
module tb_rightmove_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] I;
  logic [4:0]  amt;
  logic        arith;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] F;
  logic        sticky;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  rightmove_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .amt(amt), .arith(arith),
    .in_valid(in_valid), .in_ready(in_ready), .F(F), .sticky(sticky),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Accept one operation and count edges until out_valid (bounded).
  // Leaves the DUT in DONE with out_ready low.
  task automatic start_op(input logic [31:0] i, input logic [4:0] a,
                          input logic ar, output int lat);
    int wait_n;
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      @(posedge clk); #1; wait_n++;
    end
    I = i; amt = a; arith = ar; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Post-accept input changes must not matter.
    I = ~i; amt = ~a; arith = ~ar;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] i,
                          input logic [4:0] a, input logic ar,
                          input logic [31:0] exp_f, input logic exp_s,
                          input int exp_lat);
    int lat;
    start_op(i, a, ar, lat);
    total++;
    if (lat !== exp_lat) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if (F !== exp_f) begin
      bad++; $display("FAIL %s F: got %h want %h", name, F, exp_f);
    end
    total++;
    if (sticky !== exp_s) begin
      bad++; $display("FAIL %s sticky: got %b want %b", name, sticky, exp_s);
    end
    consume();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL %s in_ready after consume: got %b want 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; I = '0; amt = '0; arith = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    total++; if (F !== 32'h0) begin bad++; $display("FAIL reset F: got %h want 0", F); end
    total++; if (sticky !== 1'b0) begin bad++; $display("FAIL reset sticky: got %b want 0", sticky); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    check_op("basic", 32'h8000_0001, 5'd1, 1'b0, 32'h4000_0000, 1'b1, 2);
    check_op("zero_amt", 32'hDEAD_BEEF, 5'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1);
  endtask

  task automatic test_sticky();
    check_op("sticky_ff", 32'h0000_00FF, 5'd4, 1'b0, 32'h0000_000F, 1'b1, 5);
    check_op("sticky_f0", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_000F, 1'b0, 5);
    check_op("max_amt", 32'h0000_0002, 5'd31, 1'b0, 32'h0000_0000, 1'b1, 32);
  endtask

  task automatic test_arith();
`ifdef RSHIFT_ARITH_EN
    check_op("arith", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 32);
    check_op("arith_off", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0, 32);
`else
    check_op("arith", 32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001, 1'b0, 32);
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'h0000_00FF, 5'd4, 1'b0, lat);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp out_valid: got %b want 1", out_valid); end
    I = 32'h1234_5678; amt = 5'd2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      total++;
      if (F !== 32'h0000_000F) begin bad++; $display("FAIL bp F cyc%0d: got %h want f", k, F); end
      total++;
      if (sticky !== 1'b1) begin bad++; $display("FAIL bp sticky cyc%0d: got %b want 1", k, sticky); end
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp hs cyc%0d: got in_ready=%b out_valid=%b want 0/1", k, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    I = 32'hFFFF_FFFF; amt = 5'd20; arith = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (F !== 32'h0) begin bad++; $display("FAIL midrst F: got %h want 0", F); end
    total++; if (sticky !== 1'b0) begin bad++; $display("FAIL midrst sticky: got %b want 0", sticky); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check_op("after_rst", 32'h0000_0010, 5'd4, 1'b0, 32'h0000_0001, 1'b0, 5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sticky();
    test_arith();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
